// File: rtl/progmem_loader_if.sv
// Byte-stream input and program-memory port B bundle for the bootloader.
// The master modport is the loader's view; the slave modport is the byte source / memory side.
interface progmem_loader_if #(
  parameter int AWIDTH = 14
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [AWIDTH-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              mem_we;
  logic [3:0]        mem_en;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_addr, mem_din, mem_we, mem_en
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_addr, mem_din, mem_we, mem_en
  );
endinterface

// File: rtl/progmem_loader.sv
// Framed byte-stream bootloader: assembles little-endian words, writes them to program
// memory port B, checks the XOR checksum and holds the CPU in reset until a good frame lands.
module progmem_loader #(
  parameter int AWIDTH = 14
) (
  input  logic                clk,
  input  logic                rstn,
  progmem_loader_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                cpu_hold
);

  typedef enum logic [2:0] {IDLE, ADDR0, ADDR1, CNT0, CNT1, DATA, WRITE, CSUM} state_t;

  state_t            state, state_nx;
  logic [AWIDTH-1:0] addr;
  logic [15:0]       cnt;
  logic [1:0]        idx;
  logic [31:0]       word;
  logic [7:0]        csum;
  logic              acc;

  assign acc = bus.rx_valid && bus.rx_ready;

  always_comb begin
    state_nx     = state;
    bus.rx_ready = rstn && (state != WRITE);
    bus.mem_we   = (state == WRITE);
    bus.mem_en   = (state == WRITE) ? 4'hF : 4'h0;
    bus.mem_addr = addr;
    bus.mem_din  = word;
    case (state)
      IDLE:  if (acc && bus.rx_data == 8'hA5) state_nx = ADDR0;
      ADDR0: if (acc) state_nx = ADDR1;
      ADDR1: if (acc) state_nx = CNT0;
      CNT0:  if (acc) state_nx = CNT1;
      CNT1:  if (acc) state_nx = ({bus.rx_data, cnt[7:0]} == 16'd0) ? CSUM : DATA;
      DATA:  if (acc && idx == 2'd3) state_nx = WRITE;
      // cnt still holds the count including the word being written this cycle
      WRITE: state_nx = (cnt == 16'd1) ? CSUM : DATA;
      CSUM:  if (acc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      addr     <= '0;
      cnt      <= '0;
      idx      <= '0;
      word     <= '0;
      csum     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: if (acc && bus.rx_data == 8'hA5) begin
          busy     <= 1'b1;
          cpu_hold <= 1'b1;
          err      <= 1'b0;
          csum     <= '0;
        end
        ADDR0: if (acc) begin
          addr <= AWIDTH'(bus.rx_data);
          csum <= csum ^ bus.rx_data;
        end
        // address bits above AWIDTH are dropped by the cast
        ADDR1: if (acc) begin
          addr <= AWIDTH'({bus.rx_data, addr[7:0]});
          csum <= csum ^ bus.rx_data;
        end
        CNT0: if (acc) begin
          cnt  <= {8'h00, bus.rx_data};
          csum <= csum ^ bus.rx_data;
        end
        CNT1: if (acc) begin
          cnt  <= {bus.rx_data, cnt[7:0]};
          idx  <= 2'd0;
          csum <= csum ^ bus.rx_data;
        end
        DATA: if (acc) begin
          word[{idx, 3'b000} +: 8] <= bus.rx_data;
          idx  <= idx + 2'd1;
          csum <= csum ^ bus.rx_data;
        end
        WRITE: begin
          addr <= addr + 1'b1;
          cnt  <= cnt - 16'd1;
        end
        CSUM: if (acc) begin
          err      <= (bus.rx_data != csum);
          cpu_hold <= (bus.rx_data != csum);
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
